exe_stage: RTL
==============

# exe_stage

Execute stage of the 16-bit RSA ASIP pipeline, sitting on the read side of the ID/EXE pipeline register. It consumes the decoded operands and control bits, computes ADD/SUB in one cycle and MUL/MOD iteratively, and stalls the front end while an iterative op runs. It resolves conditional jumps and presents a registered result bundle to the EXE/MEM register.

## Interface
- ARQ, 16, datapath width; iterative ops take ARQ iterations
- JW, 13, jump address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- valid_in  in  1  ID/EXE holds a live instruction
- wb_enable_in, mem_enable_in  in  1 each  writeback / memory enables
- mux_exe_in  in  1  operand B select: 1 = imm_in, 0 = src2_in
- jop_lsb_in  in  1  conditional jump: taken if result == 0
- src1_in, src2_in, srcdest_in, imm_in  in  ARQ each  operands; srcdest passed through
- alu_op_in  in  2  00 ADD, 01 SUB, 10 MUL, 11 MOD
- jaddr_in  in  JW  jump target
- stall_out  out  1  combinational; freeze PC, IF/ID, ID/EXE
- valid_out, wb_enable_out, mem_enable_out  out  1 each  one-cycle result strobes
- result_out, srcdest_out  out  ARQ each  registered result / passthrough
- zero_out  out  1  result_out == 0
- branch_taken_out  out  1  one-cycle jump strobe
- branch_addr_out  out  JW  jump target

## Operation
- A = src1_in; B = mux_exe_in ? imm_in : src2_in.
- ADD/SUB: modulo 2^ARQ, carry/borrow discarded.
- MUL: shift-add, low ARQ bits of A*B.
- MOD: restoring remainder, A mod B, unsigned; B == 0 gives result A.
- FSM IDLE/BUSY. IDLE + valid_in + MUL/MOD: capture A, B, controls, srcdest, jaddr; go BUSY, count = 0. Each BUSY cycle performs one iteration and increments count. Iteration count == ARQ-1 commits the result and returns to IDLE.
- The block samples no inputs while BUSY.
- stall_out = rst & ((IDLE & valid_in & op is MUL/MOD) | (BUSY & count != ARQ-1)).
- Completion (single-cycle op in IDLE, or last BUSY iteration):
  - valid_out = 1
  - wb_enable_out / mem_enable_out = captured enables
  - branch_taken_out = jop_lsb & (result == 0)
  - result_out, srcdest_out, branch_addr_out, zero_out load
- Non-completion cycles: valid_out, wb_enable_out, mem_enable_out and branch_taken_out are 0. Data outputs hold their last value.
- valid_in = 0 in IDLE: no update, strobes 0.

## Timing
- Reset (rst = 0 at an edge): state IDLE, count 0, all outputs 0. stall_out is forced 0 while rst = 0. Reset during BUSY abandons the op, with no completion strobe.
- ADD/SUB: inputs present in cycle T, outputs valid in T+1. Back-to-back issue every cycle.
- MUL/MOD: inputs present in cycle T.
  - stall_out high in cycles T through T+ARQ-1 (ARQ cycles).
  - BUSY in cycles T+1 through T+ARQ.
  - Outputs valid in T+ARQ+1.
- stall_out falls during cycle T+ARQ, so ID/EXE loads the next instruction at the end of T+ARQ. The block sees it in IDLE at T+ARQ+1, giving zero bubble after completion.
- Held inputs: ID/EXE contents during a stall are ignored beyond the capture at the end of T.
- Branch strobe coincides with valid_out. Upstream flush is the consumer's job.

## Configuration
- EXE_MOD_EN defined: alu_op 11 = iterative MOD as above.
- EXE_MOD_EN undefined: alu_op 11 = single-cycle bitwise AND (A & B). No stall, latency 1, and no remainder hardware is synthesized.

## Test plan
- ADD with immediate: src1 = 152, imm = 450, mux_exe = 1, op 00, wb = 1 -> next cycle result 602, valid 1, wb 1, stall never high.
- SUB with jump: src1 = 155, src2 = 155, mux_exe = 0, op 01, jop = 1, jaddr = 1254 -> next cycle result 0, zero 1, branch_taken 1, branch_addr 1254.
- MUL: 300 * 200 -> stall high exactly 16 cycles, result 60000 at T+17. Next ADD held in ID/EXE completes at T+18.
- MOD with EXE_MOD_EN: 450 mod 152 -> 146 after 16 stall cycles. B = 0 -> result = src1. Without the macro, op 11 on 0x00F0 & 0x0FF0 -> 0x00F0 next cycle, no stall.
- Reset mid-MUL: drive rst = 0 at T+5 -> stall 0 and all outputs 0 next cycle, no valid_out pulse afterwards.
- Idle bubble: valid_in = 0 for 3 cycles between ops -> valid_out 0, result_out holds prior value.

Source files
------------

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Purpose  : Execute stage of the 16-bit RSA ASIP pipeline. ADD/SUB finish in
//            one cycle; MUL (shift-add) and MOD (restoring remainder) run for
//            ARQ iterations while stall_out freezes the front end. Resolves
//            conditional jumps and drives a registered result bundle.
// Config   : `define EXE_MOD_EN -> alu_op 11 is iterative MOD.
//            Undefined          -> alu_op 11 is single-cycle A & B and the
//                                  remainder datapath is not built.
// Ports    : clk, rst (sync, active-low)
//            valid_in, wb/mem_enable_in, mux_exe_in, jop_lsb_in,
//            src1/src2/srcdest/imm_in [ARQ], alu_op_in [2], jaddr_in [JW]
//            stall_out (comb), valid/wb/mem_enable_out (strobes),
//            result/srcdest_out [ARQ], zero_out, branch_taken_out,
//            branch_addr_out [JW]
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage #(
    parameter int ARQ = 16,
    parameter int JW  = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic           wb_enable_in,
    input  logic           mem_enable_in,
    input  logic           mux_exe_in,
    input  logic           jop_lsb_in,
    input  logic [ARQ-1:0] src1_in,
    input  logic [ARQ-1:0] src2_in,
    input  logic [ARQ-1:0] srcdest_in,
    input  logic [ARQ-1:0] imm_in,
    input  logic [1:0]     alu_op_in,
    input  logic [JW-1:0]  jaddr_in,
    output logic           stall_out,
    output logic           valid_out,
    output logic           wb_enable_out,
    output logic           mem_enable_out,
    output logic [ARQ-1:0] result_out,
    output logic [ARQ-1:0] srcdest_out,
    output logic           zero_out,
    output logic           branch_taken_out,
    output logic [JW-1:0]  branch_addr_out
);

    localparam int            CW          = (ARQ > 1) ? $clog2(ARQ) : 1;
    localparam logic [CW-1:0] c_last_iter = CW'(ARQ - 1);
    localparam logic [0:0]    c_st_idle   = 1'b0;
    localparam logic [0:0]    c_st_busy   = 1'b1;
    localparam logic [1:0]    c_op_add    = 2'b00;
    localparam logic [1:0]    c_op_sub    = 2'b01;
    localparam logic [1:0]    c_op_mul    = 2'b10;

    // Iterative-op working registers. r_a shifts left for both MUL
    // (multiplicand) and MOD (dividend bits fed MSB first); r_b shifts right
    // for MUL (multiplier) and holds the divisor for MOD.
    logic [0:0]     r_state;
    logic [CW-1:0]  r_count;
    logic [ARQ-1:0] r_a;
    logic [ARQ-1:0] r_b;
    logic [ARQ-1:0] r_acc;
    logic           r_wb;
    logic           r_mem;
    logic           r_jop;
    logic [ARQ-1:0] r_srcdest;
    logic [JW-1:0]  r_jaddr;
`ifdef EXE_MOD_EN
    logic           r_is_mod;
`endif

    // Registered output bundle
    logic           r_valid_out;
    logic           r_wb_out;
    logic           r_mem_out;
    logic [ARQ-1:0] r_result;
    logic [ARQ-1:0] r_srcdest_out;
    logic           r_zero;
    logic           r_branch;
    logic [JW-1:0]  r_baddr;

    logic [ARQ-1:0] w_b;
    logic           w_is_iter;
    logic [ARQ-1:0] w_single_res;
    logic [ARQ-1:0] w_mul_acc;
    logic [ARQ-1:0] w_iter_res;
    logic [0:0]     w_state_nxt;
    logic           w_capture;
    logic           w_done;
    logic [ARQ-1:0] w_done_res;
    logic           w_done_wb;
    logic           w_done_mem;
    logic           w_done_jop;
    logic [ARQ-1:0] w_done_sd;
    logic [JW-1:0]  w_done_ja;
    logic           w_done_zero;

    assign w_b = mux_exe_in ? imm_in : src2_in;

`ifdef EXE_MOD_EN
    assign w_is_iter = alu_op_in[1];
`else
    assign w_is_iter = (alu_op_in == c_op_mul);
`endif

    // Single-cycle ALU; the AND arm is only reachable for op 11 when MOD
    // is not built.
    always_comb begin
        w_single_res = src1_in & w_b;
        case (alu_op_in)
            c_op_add: w_single_res = src1_in + w_b;
            c_op_sub: w_single_res = src1_in - w_b;
            default:  w_single_res = src1_in & w_b;
        endcase
    end

    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

`ifdef EXE_MOD_EN
    // Restoring remainder step: shift next dividend bit into the partial
    // remainder, subtract divisor when it fits. A zero divisor always
    // "fits" with no change, so the final remainder equals the dividend.
    logic [ARQ:0]   w_rem_sh;
    logic           w_rem_ge;
    logic [ARQ-1:0] w_rem_nxt;

    assign w_rem_sh   = {r_acc, r_a[ARQ-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_nxt  = w_rem_ge ? ARQ'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[ARQ-1:0];
    assign w_iter_res = r_is_mod ? w_rem_nxt : w_mul_acc;
`else
    assign w_iter_res = w_mul_acc;
`endif

    // Next-state and completion selection
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        w_done_res  = w_single_res;
        w_done_wb   = wb_enable_in;
        w_done_mem  = mem_enable_in;
        w_done_jop  = jop_lsb_in;
        w_done_sd   = srcdest_in;
        w_done_ja   = jaddr_in;
        case (r_state)
            c_st_idle: begin
                if (valid_in) begin
                    if (w_is_iter) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_st_busy;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            c_st_busy: begin
                w_done_res = w_iter_res;
                w_done_wb  = r_wb;
                w_done_mem = r_mem;
                w_done_jop = r_jop;
                w_done_sd  = r_srcdest;
                w_done_ja  = r_jaddr;
                if (r_count == c_last_iter) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    assign w_done_zero = (w_done_res == '0);

    // Stall drops in the last BUSY cycle so ID/EXE reloads with no bubble.
    assign stall_out = rst &
                       (((r_state == c_st_idle) & valid_in & w_is_iter) |
                        ((r_state == c_st_busy) & (r_count != c_last_iter)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_st_idle;
            r_count       <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_acc         <= '0;
            r_wb          <= 1'b0;
            r_mem         <= 1'b0;
            r_jop         <= 1'b0;
            r_srcdest     <= '0;
            r_jaddr       <= '0;
`ifdef EXE_MOD_EN
            r_is_mod      <= 1'b0;
`endif
            r_valid_out   <= 1'b0;
            r_wb_out      <= 1'b0;
            r_mem_out     <= 1'b0;
            r_result      <= '0;
            r_srcdest_out <= '0;
            r_zero        <= 1'b0;
            r_branch      <= 1'b0;
            r_baddr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid_out <= w_done;
            r_wb_out    <= w_done & w_done_wb;
            r_mem_out   <= w_done & w_done_mem;
            r_branch    <= w_done & w_done_jop & w_done_zero;
            if (w_done) begin
                r_result      <= w_done_res;
                r_srcdest_out <= w_done_sd;
                r_baddr       <= w_done_ja;
                r_zero        <= w_done_zero;
            end
            if (w_capture) begin
                r_a       <= src1_in;
                r_b       <= w_b;
                r_acc     <= '0;
                r_count   <= '0;
                r_wb      <= wb_enable_in;
                r_mem     <= mem_enable_in;
                r_jop     <= jop_lsb_in;
                r_srcdest <= srcdest_in;
                r_jaddr   <= jaddr_in;
`ifdef EXE_MOD_EN
                r_is_mod  <= alu_op_in[0];
`endif
            end else if (r_state == c_st_busy) begin
                r_a     <= r_a << 1;
`ifdef EXE_MOD_EN
                r_b     <= r_is_mod ? r_b : (r_b >> 1);
`else
                r_b     <= r_b >> 1;
`endif
                r_acc   <= w_iter_res;
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign valid_out        = r_valid_out;
    assign wb_enable_out    = r_wb_out;
    assign mem_enable_out   = r_mem_out;
    assign result_out       = r_result;
    assign srcdest_out      = r_srcdest_out;
    assign zero_out         = r_zero;
    assign branch_taken_out = r_branch;
    assign branch_addr_out  = r_baddr;

endmodule
`default_nettype wire
